// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps s1/s0 through enabled channels, samples y, builds a frame.
// Optional continuous rescan when MUX4_SCAN_CONT_EN is defined.
module mux4_scan_ctrl #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               sample_valid,
    output logic [1:0]         sample_ch,
    output logic               sample_bit,
    output logic [3:0]         frame,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         frame_q, frame_d;
    logic               sv_q, sv_d;
    logic [1:0]         sch_q, sch_d;
    logic               sbit_q, sbit_d;
    logic               done_q, done_d;

    logic [3:0]         above;
    logic               more;
    logic [1:0]         next_ch;
    logic               restart;
    logic               accept;
    logic [DWELL_W-1:0] dwell_eff;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

`ifdef MUX4_SCAN_CONT_EN
    assign restart = (state_q == StDone) && !abort;
`else
    assign restart = 1'b0;
`endif

    assign accept    = start && (ch_en != 4'd0) && ((state_q == StIdle) || restart);
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // Enabled channels strictly above the current select.
    always_comb begin
        above   = mask_q & (4'b1110 << sel_q);
        more    = |above;
        next_ch = lowest_ch(above);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mask_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            frame_q <= '0;
            sv_q    <= 1'b0;
            sch_q   <= '0;
            sbit_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            sv_q    <= sv_d;
            sch_q   <= sch_d;
            sbit_q  <= sbit_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSettle;
            StSettle: begin
                if (abort)                        state_d = StIdle;
                else if (cnt_q <= DWELL_W'(1))    state_d = StSample;
            end
            StSample: begin
                if (abort)     state_d = StIdle;
                else if (more) state_d = StSettle;
                else           state_d = StDone;
            end
            StDone:   state_d = accept ? StSettle : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        frame_d = frame_q;
        sv_d    = 1'b0;
        sch_d   = sch_q;
        sbit_d  = sbit_q;
        done_d  = (state_q == StDone);

        if (accept) begin
            mask_d  = ch_en;
            dwell_d = dwell_eff;
            cnt_d   = dwell_eff;
            frame_d = '0;
            sel_d   = lowest_ch(ch_en);
        end else if (state_q == StSettle && !abort) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end else if (state_q == StSample && !abort) begin
            frame_d[sel_q] = y;
            sv_d           = 1'b1;
            sch_d          = sel_q;
            sbit_d         = y;
            if (more) begin
                sel_d = next_ch;
                cnt_d = dwell_q;
            end
        end
    end

    always_comb begin
        s1           = sel_q[1];
        s0           = sel_q[0];
        busy         = (state_q == StSettle) || (state_q == StSample);
        sample_valid = sv_q;
        sample_ch    = sch_q;
        sample_bit   = sbit_q;
        frame        = frame_q;
        done         = done_q;
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl: a scan-level model predicts every sample and done event
// with its cycle; a monitor pops and compares whenever the DUT presents one.
module tb_mux4_scan_ctrl;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    ch_en = 4'd0;
    logic [DW-1:0] dwell = '0;
    logic          y;
    logic          s0, s1, busy, sample_valid, sample_bit, done;
    logic [1:0]    sample_ch;
    logic [3:0]    frame;
    logic [3:0]    ivec = 4'd0;

    mux4_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .ch_en        (ch_en),
        .dwell        (dwell),
        .y            (y),
        .s0           (s0),
        .s1           (s1),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_bit   (sample_bit),
        .frame        (frame),
        .done         (done)
    );

    // Reference 4:1 mux downstream of the select lines.
    assign y = ivec[{s1, s0}];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [1:0] ch;
        logic       bitv;
        logic [3:0] frame;
        int         at;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_frame = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per DUT event.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (sample_valid) begin
                if (q.size() == 0) check("unexpected sample_valid", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("event kind (sample)", {31'd0, e.is_done}, 32'd0);
                    check("sample_ch", {30'd0, sample_ch}, {30'd0, e.ch});
                    check("sample_bit", {31'd0, sample_bit}, {31'd0, e.bitv});
                    check("sample cycle", cyc, e.at);
                end
            end
            if (done) begin
                if (q.size() == 0) check("unexpected done", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("event kind (done)", {31'd0, e.is_done}, 32'd1);
                    check("done frame", {28'd0, frame}, {28'd0, e.frame});
                    check("done cycle", cyc, e.at);
                end
            end
        end
    end

    // Scan-level model: the k-th enabled channel is sampled in cycle T+(k+1)*(D+1); an abort
    // raised in cycle A cancels every sample at or after A, and done only when A lies past the
    // last sample.
    task automatic push_model(input logic [3:0] m, input int d_eff, input logic [3:0] iv,
                              input int t0, input int a_cyc);
        int         k;
        int         s;
        logic [3:0] fr;
        exp_t       e;
        k  = 0;
        fr = 4'd0;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                s = t0 + (k + 1) * (d_eff + 1);
                if (s < a_cyc) begin
                    fr[c]     = iv[c];
                    e.is_done = 1'b0;
                    e.ch      = 2'(c);
                    e.bitv    = iv[c];
                    e.frame   = 4'd0;
                    e.at      = s + 1;
                    q.push_back(e);
                end
                k++;
            end
        end
        if (m != 4'd0) begin
            if (a_cyc > t0 + k * (d_eff + 1)) begin
                e.is_done = 1'b1;
                e.ch      = 2'd0;
                e.bitv    = 1'b0;
                e.frame   = fr;
                e.at      = t0 + k * (d_eff + 1) + 2;
                q.push_back(e);
            end
            exp_frame = fr;
        end
    endtask

    // Call right after a posedge (+1). abort_rel/spur_rel are cycles after start, 0 = none.
    task automatic run_scan(input logic [3:0] m, input logic [DW-1:0] d, input logic [3:0] iv,
                            input int abort_rel, input int spur_rel);
        int t0;
        int d_eff;
        int n;
        int a_cyc;
        d_eff = (d == '0) ? 1 : int'(d);
        n     = $countones(m);
        ch_en = m;
        dwell = d;
        ivec  = iv;
        start = 1'b1;
        t0    = cyc;
        a_cyc = (abort_rel > 0) ? t0 + abort_rel : 32'h7fff_ffff;
        push_model(m, d_eff, iv, t0, a_cyc);
        for (int r = 1; r <= n * (d_eff + 1) + 4; r++) begin
            @(posedge clk);
            #1;
            if (r == 1) check("busy after start", {31'd0, busy}, {31'd0, (m != 4'd0)});
            abort = (r == abort_rel);
            if (r == spur_rel) begin
                start = 1'b1;
                ch_en = 4'($urandom);
                dwell = DW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check("idle busy", {31'd0, busy}, 32'd0);
        check("frame after scan", {28'd0, frame}, {28'd0, exp_frame});
        check("queue drained", q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin : stim
        int t0;
        int a_rel;
        int s_rel;
        int n;
        int d_eff;
        logic [3:0]    m;
        logic [DW-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset sel", {30'd0, s1, s0}, 32'd0);
        check("reset frame", {28'd0, frame}, 32'd0);
        check("reset done/valid", {30'd0, done, sample_valid}, 32'd0);
        check("reset sample", {29'd0, sample_ch, sample_bit}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_scan(4'b1111, DW'(2), 4'b1101, 0, 0);
        run_scan(4'b1010, DW'(0), 4'($urandom), 0, 0);
        run_scan(4'b0000, DW'(3), 4'($urandom), 0, 0);
        run_scan(4'b0110, DW'(1), 4'($urandom), 0, 2);
        run_scan(4'b1111, DW'(3), 4'b1011, 10, 0);
        check("abort frame", {28'd0, frame}, {28'd0, 4'b0011});

        // Asynchronous reset in the middle of a scan.
        ch_en = 4'b1111;
        dwell = DW'(2);
        ivec  = 4'b0001;
        start = 1'b1;
        t0    = cyc;
        push_model(4'b1111, 2, 4'b0001, t0, 32'h7fff_ffff);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset frame", {28'd0, frame}, 32'd0);
        check("async reset sel", {30'd0, s1, s0}, 32'd0);
        check("async reset outs", {28'd0, done, sample_valid, sample_ch}, 32'd0);
        q.delete();
        exp_frame = 4'd0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post-reset idle", {31'd0, busy}, 32'd0);
        check("post-reset frame", {28'd0, frame}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            m     = 4'($urandom_range(0, 15));
            d     = DW'($urandom_range(0, 5));
            d_eff = (d == '0) ? 1 : int'(d);
            n     = $countones(m);
            a_rel = 0;
            s_rel = 0;
            if (n != 0 && $urandom_range(0, 3) == 0)
                a_rel = $urandom_range(1, n * (d_eff + 1) + 2);
            if (n != 0 && $urandom_range(0, 2) == 0) begin
                s_rel = $urandom_range(1, n * (d_eff + 1));
                if (a_rel != 0 && s_rel >= a_rel) s_rel = 0;
            end
            run_scan(m, d, 4'($urandom), a_rel, s_rel);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
